cv32e40p_fetch_fifo: RTL and testbench
======================================

// Module: cv32e40p_fetch_fifo
//
// PURPOSE
//  Prefetch FIFO between the instruction-memory response path and the IF-stage fetch FSM.
//  - Buffers fetched instruction words with their addresses.
//  - Presents them first-word-fall-through as fetch_valid.
//  - Consumes the FSM's fetch_ready (pop) and branch_req (flush).
//  - Supplies the fetch_valid input of the IF-stage FSM logic, including its triplicated variant.
//
// PARAMETERS
//  DEPTH   4   entries; power of two, >= 2
//  DATA_W  32  instruction word width
//  ADDR_W  32  fetch address width
//  CNT_W   $clog2(DEPTH)+1  derived occupancy width; do not override
//
// PORTS
//  clk          in   1       clock; all state updates on rising edge
//  rst_n        in   1       reset; synchronous, active-low
//  flush_i      in   1       discard all contents (driven by branch_req)
//  in_valid_i   in   1       memory response word valid
//  in_rdata_i   in   DATA_W  response instruction word
//  in_addr_i    in   ADDR_W  address of in_rdata_i
//  in_ready_o   in/out: out 1       space available (count < DEPTH)
//  out_valid_o  out  1       head entry valid (fetch_valid)
//  out_rdata_o  out  DATA_W  head instruction word
//  out_addr_o   out  ADDR_W  head address
//  out_ready_i  in   1       consumer accepts head (fetch_ready)
//  cnt_o        out  CNT_W   current occupancy 0..DEPTH
//  par_err_o    out  1       parity error on a popped entry (see CONFIGURATION)
//
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): wr_ptr=rd_ptr=0, count=0, par_err_o=0. Storage is not cleared.
//    Consequences: out_valid_o=0, in_ready_o=1, cnt_o=0.
//  - Push = in_valid_i & in_ready_o. Pop = out_valid_o & out_ready_i.
//  - in_ready_o = (count != DEPTH).
//    - Combinational from count only; never depends on a same-cycle pop.
//    - No push while full, even if popping in that cycle.
//  - out_valid_o = (count != 0) & ~flush_i.
//    - out_rdata_o/out_addr_o are driven from mem[rd_ptr].
//    - Values when out_valid_o=0 are don't-care.
//  - Latency is 1 cycle, with no bypass: a word pushed at edge N is visible at the head after edge N.
//    This holds also when the FIFO is empty.
//  - Pointers are $clog2(DEPTH) bits, increment on push/pop and wrap modulo DEPTH.
//    count is tracked separately: +1 push only, -1 pop only, unchanged on push+pop.
//  - Simultaneous push and pop (0 < count < DEPTH): both pointers advance; count is unchanged.
//  - Flush has priority over everything:
//    - Next state is wr_ptr=rd_ptr=0, count=0.
//    - A push or pop in the flush cycle is discarded.
//    - in_ready_o stays as computed, but an accepted push is dropped.
//  - Reset has priority over flush.
//  - Reset mid-stream empties the FIFO exactly as at power-up.
//  - Overflow/underflow are impossible by construction.
//    - Assertions: no push when count==DEPTH; no pop when count==0.
//
// CONFIGURATION
//  Macro CV32E40P_FETCH_FIFO_PARITY_EN.
//  - Defined:
//    - Each entry stores one extra bit = ^{in_addr_i, in_rdata_i} (even parity), written on push.
//    - On pop, parity is recomputed over the head entry and compared with the stored bit.
//    - A mismatch drives par_err_o=1 for exactly the next cycle (registered pulse).
//    - par_err_o is cleared by reset. Flush does not mask a pulse already registered.
//  - Undefined: no parity storage or logic; par_err_o tied to 1'b0.
//  - The port list is identical in both builds.
//
// STRUCTURE
//  - Shared package cv32e40p_pkg:
//    - FETCH_FIFO_DEPTH = 4 default.
//    - typedef struct packed fetch_entry_t {addr, rdata}.
//  - Sub-module cv32e40p_fetch_fifo_mem: DEPTH x entry register array.
//    - Write port (we, waddr, wdata); async read port.
//    - Parity bit included when the macro is defined.
//  - Pointer, count and handshake logic live in this module.
//
// TESTING
//  1. Reset with in_valid_i=1 held -> out_valid_o=0, cnt_o=0, in_ready_o=1 throughout reset.
//  2. Push A0..A3 (0x1000..0x100C), out_ready_i=0 -> cnt_o=4, in_ready_o=0.
//     A fifth push is refused; popping 4 yields 0x1000,0x1004,0x1008,0x100C in order.
//  3. count=2 with continuous push+pop for 10 cycles -> cnt_o stays 2.
//     Pointers wrap at least twice; order is preserved.
//  4. count=3, flush_i=1 together with push and pop -> next cycle cnt_o=0, out_valid_o=0.
//     The pushed word never appears.
//  5. Empty FIFO, push at edge N -> out_valid_o first high after edge N, never in the push cycle.
//  6. PARITY_EN build: force-flip bit 5 of a stored rdata, then pop it -> par_err_o=1 for exactly one cycle.
//     Uncorrupted pops keep par_err_o=0. Non-parity build: par_err_o is always 0.

Source files
------------

// File: rtl/cv32e40p_pkg.sv
// Shared definitions for the cv32e40p fetch path.
//   FETCH_FIFO_DEPTH : default prefetch FIFO depth
//   fetch_entry_t    : one buffered fetch word, {addr, rdata}. The FIFO storage
//                      uses this same field order: addr in the upper bits and
//                      rdata in the lower bits.
package cv32e40p_pkg;

    localparam int FETCH_FIFO_DEPTH = 4;
    localparam int FETCH_ADDR_W     = 32;
    localparam int FETCH_DATA_W     = 32;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] addr;
        logic [FETCH_DATA_W-1:0] rdata;
    } fetch_entry_t;

endpackage

// File: rtl/cv32e40p_fetch_fifo_mem.sv
// Register array that backs the fetch FIFO. There is one synchronous write
// port and one asynchronous read port. Storage has no reset because only
// entries marked valid by the FIFO count are ever observed.
//   clk   : clock
//   we    : write enable
//   waddr : write slot
//   wdata : entry written (including the parity bit when CV32E40P_FETCH_FIFO_PARITY_EN)
//   raddr : read slot
//   rdata : entry at raddr (combinational)
module cv32e40p_fetch_fifo_mem #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/cv32e40p_fetch_fifo.sv
// Prefetch FIFO between the instruction-memory response path and the IF-stage
// fetch FSM. The output is first-word-fall-through. A word pushed at one clock
// edge appears at the head after that edge; there is no bypass path.
// Optional feature: define CV32E40P_FETCH_FIFO_PARITY_EN to store an even-parity
// bit per entry and report a one-cycle par_err_o pulse when a corrupted entry
// is popped. When the macro is undefined, par_err_o is tied to 0.
//   clk, rst_n              : clock and synchronous active-low reset
//   flush_i                 : drop all contents (branch_req); takes priority over push and pop
//   in_valid_i/in_rdata_i/in_addr_i, in_ready_o : push side
//   out_valid_o/out_rdata_o/out_addr_o, out_ready_i : pop side (fetch_valid / fetch_ready)
//   cnt_o                   : occupancy, 0..DEPTH
//   par_err_o               : registered parity-error pulse
module cv32e40p_fetch_fifo
    import cv32e40p_pkg::*;
#(
    parameter int DEPTH  = FETCH_FIFO_DEPTH,
    parameter int DATA_W = FETCH_DATA_W,
    parameter int ADDR_W = FETCH_ADDR_W,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_rdata_i,
    input  logic [ADDR_W-1:0] in_addr_i,
    output logic              in_ready_o,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_rdata_o,
    output logic [ADDR_W-1:0] out_addr_o,
    input  logic              out_ready_i,
    output logic [CNT_W-1:0]  cnt_o,
    output logic              par_err_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int PAY_W = ADDR_W + DATA_W;
`ifdef CV32E40P_FETCH_FIFO_PARITY_EN
    localparam int ENTRY_W = PAY_W + 1;
`else
    localparam int ENTRY_W = PAY_W;
`endif

    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               push, pop;
    logic [ENTRY_W-1:0] wdata, rdata;

    // in_ready_o depends only on count. A full FIFO refuses a push even in a
    // cycle where it also pops.
    assign in_ready_o  = (count_q != CNT_W'(DEPTH));
    assign out_valid_o = (count_q != '0) & ~flush_i;
    assign push        = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;   // out_valid_o already masks the pop during flush
    assign cnt_o       = count_q;

`ifdef CV32E40P_FETCH_FIFO_PARITY_EN
    assign wdata = {^{in_addr_i, in_rdata_i}, in_addr_i, in_rdata_i};
`else
    assign wdata = {in_addr_i, in_rdata_i};
`endif

    // A push accepted in the flush cycle is dropped, so it is never written.
    cv32e40p_fetch_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_mem (
        .clk   (clk),
        .we    (push & ~flush_i),
        .waddr (wr_ptr_q),
        .wdata (wdata),
        .raddr (rd_ptr_q),
        .rdata (rdata)
    );

    assign out_rdata_o = rdata[DATA_W-1:0];
    assign out_addr_o  = rdata[PAY_W-1:DATA_W];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef CV32E40P_FETCH_FIFO_PARITY_EN
    logic par_err_q;

    // Flush does not mask this pulse. A pop cannot coincide with a flush,
    // so a flush never creates a new pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) par_err_q <= 1'b0;
        else        par_err_q <= pop & (rdata[ENTRY_W-1] != ^rdata[PAY_W-1:0]);
    end

    assign par_err_o = par_err_q;
`else
    assign par_err_o = 1'b0;
`endif

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && count_q == CNT_W'(DEPTH)));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(pop && count_q == '0));

endmodule

// File: tb/tb_cv32e40p_fetch_fifo.sv
module tb_cv32e40p_fetch_fifo;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush_i = 1'b0;
    logic        in_valid_i = 1'b0;
    logic [31:0] in_rdata_i = '0;
    logic [31:0] in_addr_i = '0;
    logic        in_ready_o, out_valid_o, out_ready_i, par_err_o;
    logic [31:0] out_rdata_o, out_addr_o;
    logic [2:0]  cnt_o;

    initial out_ready_i = 1'b0;

    always #5 clk = ~clk;

    cv32e40p_fetch_fifo dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_rdata_i  (in_rdata_i),
        .in_addr_i   (in_addr_i),
        .in_ready_o  (in_ready_o),
        .out_valid_o (out_valid_o),
        .out_rdata_o (out_rdata_o),
        .out_addr_o  (out_addr_o),
        .out_ready_i (out_ready_i),
        .cnt_o       (cnt_o),
        .par_err_o   (par_err_o)
    );

    // Reference model: an ordered queue of buffered words. wr_slot is the
    // storage slot the next push lands in; it is used only to locate an entry
    // when corrupting storage.
    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        bit          bad;
    } ent_t;

    ent_t q[$];
    int   wr_slot = 0;
    bit   exp_par = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [31:0] next_addr = 32'h0000_2000;

    // One clock cycle: apply inputs, check outputs against the model, clock,
    // then advance the model.
    task automatic step(input bit v, input logic [31:0] a, input logic [31:0] d,
                        input bit rdy, input bit fl);
        bit   ev, ep_push, ep_pop;
        ent_t e;
        in_valid_i = v; in_addr_i = a; in_rdata_i = d; out_ready_i = rdy; flush_i = fl;
        #1;
        ev = (q.size() != 0) && !fl;
        n_cmp++;
        if (cnt_o !== 3'(q.size())) begin
            n_err++; $display("FAIL cnt: got %0d want %0d", cnt_o, q.size());
        end
        n_cmp++;
        if (in_ready_o !== (q.size() != DEPTH)) begin
            n_err++; $display("FAIL in_ready: got %b want %b", in_ready_o, q.size() != DEPTH);
        end
        n_cmp++;
        if (out_valid_o !== ev) begin
            n_err++; $display("FAIL out_valid: got %b want %b", out_valid_o, ev);
        end
        if (ev) begin
            n_cmp++;
            if (out_addr_o !== q[0].a || out_rdata_o !== q[0].d) begin
                n_err++;
                $display("FAIL head: got %h/%h want %h/%h", out_addr_o, out_rdata_o, q[0].a, q[0].d);
            end
        end
        n_cmp++;
        if (par_err_o !== exp_par) begin
            n_err++; $display("FAIL par_err: got %b want %b", par_err_o, exp_par);
        end
        ep_push = v && (q.size() < DEPTH);
        ep_pop  = rdy && (q.size() != 0) && !fl;
        @(posedge clk);
        if (!rst_n) begin
            q.delete(); wr_slot = 0; exp_par = 1'b0;
        end else begin
            exp_par = ep_pop && q[0].bad;
            if (fl) begin
                q.delete(); wr_slot = 0;
            end else begin
                if (ep_pop) void'(q.pop_front());
                if (ep_push) begin
                    e.a = a; e.d = d; e.bad = 1'b0;
                    q.push_back(e);
                    wr_slot = (wr_slot + 1) % DEPTH;
                end
            end
        end
        #1;
    endtask

    task automatic push_n(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1, next_addr, $urandom, 1'b0, 1'b0);
            next_addr += 32'd4;
        end
    endtask

    task automatic do_flush();
        step(1'b0, '0, '0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) step(1'b1, 32'hABCD_0000 + i, $urandom, 1'b1, 1'b0);
        rst_n = 1'b1;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) step(1'b1, 32'h1000 + 32'(4 * i), $urandom, 1'b0, 1'b0);
        n_cmp++;
        if (cnt_o !== 3'd4 || in_ready_o !== 1'b0) begin
            n_err++; $display("FAIL full: cnt %0d ready %b want 4/0", cnt_o, in_ready_o);
        end
        step(1'b1, 32'h1010, $urandom, 1'b0, 1'b0);   // refused
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (out_addr_o !== 32'h1000 + 32'(4 * i)) begin
                n_err++; $display("FAIL order: got %h want %h", out_addr_o, 32'h1000 + 32'(4 * i));
            end
            step(1'b0, '0, '0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        do_flush();
        push_n(2);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, next_addr, $urandom, 1'b1, 1'b0);
            next_addr += 32'd4;
            n_cmp++;
            if (cnt_o !== 3'd2) begin
                n_err++; $display("FAIL b2b_cnt: got %0d want 2", cnt_o);
            end
        end
    endtask

    task automatic test_flush();
        do_flush();
        push_n(3);
        step(1'b1, 32'hDEAD_0000, $urandom, 1'b1, 1'b1);
        n_cmp++;
        if (cnt_o !== 3'd0 || out_valid_o !== 1'b0) begin
            n_err++; $display("FAIL flush: cnt %0d valid %b want 0/0", cnt_o, out_valid_o);
        end
        push_n(1);
        n_cmp++;
        if (out_addr_o === 32'hDEAD_0000) begin
            n_err++; $display("FAIL flush_drop: got %h want not DEAD0000", out_addr_o);
        end
        step(1'b0, '0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_latency();
        logic [31:0] a;
        do_flush();
        a = next_addr;
        push_n(1);   // out_valid_o is checked low inside the push cycle
        n_cmp++;
        if (out_valid_o !== 1'b1 || out_addr_o !== a) begin
            n_err++; $display("FAIL latency: valid %b addr %h want 1/%h", out_valid_o, out_addr_o, a);
        end
        step(1'b0, '0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_mid_reset();
        push_n(3);
        rst_n = 1'b0;
        step(1'b1, next_addr, $urandom, 1'b1, 1'b0);
        rst_n = 1'b1;
        n_cmp++;
        if (cnt_o !== 3'd0 || out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
            n_err++; $display("FAIL mid_reset: cnt %0d valid %b ready %b", cnt_o, out_valid_o, in_ready_o);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom_range(0, 63) != 0);
            step($urandom_range(0, 2) != 0, $urandom, $urandom,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_parity();
`ifdef CV32E40P_FETCH_FIFO_PARITY_EN
        int s;
        do_flush();
        push_n(3);
        s = (wr_slot - q.size() + 1 + DEPTH) % DEPTH;   // slot of the second entry
        dut.u_mem.mem_q[s][5] = ~dut.u_mem.mem_q[s][5];
        q[1].d = q[1].d ^ 32'h20;
        q[1].bad = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) step(1'b0, '0, '0, 1'b0, 1'b0);
`else
        for (int i = 0; i < 20; i++)
            step($urandom_range(0, 1) != 0, $urandom, $urandom, $urandom_range(0, 1) != 0, 1'b0);
`endif
    endtask

    initial begin
        test_reset();
        test_fill();
        test_back_to_back();
        test_flush();
        test_latency();
        test_mid_reset();
        test_parity();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
